// File: rtl/func_gen_pkg.sv
// func_gen_pkg: shared constants for the func_gen_pipe logic unit.
//   SEL_W        width of the function select
//   FN_AND..FN_PASSA  function codes carried on sel
package func_gen_pkg;

    localparam int unsigned SEL_W = 3;

    localparam logic [SEL_W-1:0] FN_AND   = 3'd0;
    localparam logic [SEL_W-1:0] FN_OR    = 3'd1;
    localparam logic [SEL_W-1:0] FN_XOR   = 3'd2;
    localparam logic [SEL_W-1:0] FN_NAND  = 3'd3;
    localparam logic [SEL_W-1:0] FN_NOR   = 3'd4;
    localparam logic [SEL_W-1:0] FN_XNOR  = 3'd5;
    localparam logic [SEL_W-1:0] FN_NOTA  = 3'd6;
    localparam logic [SEL_W-1:0] FN_PASSA = 3'd7;

endpackage

// File: rtl/func_gen_pipe_if.sv
// func_gen_pipe_if: command/result handshake bundle of func_gen_pipe.
//   in_valid/in_ready, A, B, sel, chain : command side
//   out_valid/out_ready, F              : result side
//   modport master : command source / result sink (testbench, upstream)
//   modport slave  : the logic unit itself
interface func_gen_pipe_if
    import func_gen_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [SEL_W-1:0] sel;
    logic             chain;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] F;

    modport master (
        output in_valid, A, B, sel, chain, out_ready,
        input  in_ready, out_valid, F
    );

    modport slave (
        input  in_valid, A, B, sel, chain, out_ready,
        output in_ready, out_valid, F
    );
endinterface

// File: rtl/func_gen_core.sv
// func_gen_core: combinational WIDTH-bit bitwise evaluator.
//   a, b : operands (b unused for FN_NOTA / FN_PASSA)
//   sel  : function code from func_gen_pkg
//   f    : result
module func_gen_core
    import func_gen_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] f
);
    always_comb begin
        f = a;
        case (sel)
            FN_AND:  f = a & b;
            FN_OR:   f = a | b;
            FN_XOR:  f = a ^ b;
            FN_NAND: f = ~(a & b);
            FN_NOR:  f = ~(a | b);
            FN_XNOR: f = ~(a ^ b);
            FN_NOTA: f = ~a;
            default: f = a;
        endcase
    end
endmodule

// File: rtl/func_gen_pipe.sv
// func_gen_pipe: registered WIDTH-bit logic unit with valid/ready on both
// sides and a 2-entry (output + skid) buffer. Chain mode replaces operand A
// with the last accepted result.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : func_gen_pipe_if.slave handshake bundle
//   op_count   : accepted-operation counter, only when FUNC_GEN_STATS_EN is
//                defined (COUNT_W parameter exists only in that build)
module func_gen_pipe
    import func_gen_pkg::*;
#(
    parameter int WIDTH = 8
`ifdef FUNC_GEN_STATS_EN
    ,
    parameter int COUNT_W = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    func_gen_pipe_if.slave       bus
`ifdef FUNC_GEN_STATS_EN
    ,
    output logic [COUNT_W-1:0]   op_count
`endif
);
    logic [WIDTH-1:0] or_q, or_d;
    logic             or_v, or_v_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             sr_v, sr_v_d;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] result;
    logic             accept;
    logic             pop;

    // in_ready comes straight from the skid-valid flop, so it is registered.
    assign bus.in_ready  = !sr_v;
    assign bus.out_valid = or_v;
    assign bus.F         = or_q;

    assign accept = bus.in_valid && !sr_v;
    assign pop    = or_v && bus.out_ready;
    assign op_a   = bus.chain ? acc : bus.A;

    func_gen_core #(.WIDTH(WIDTH)) u_core (
        .a   (op_a),
        .b   (bus.B),
        .sel (bus.sel),
        .f   (result)
    );

    // accept is impossible while the skid entry is full, so a pop with SR
    // full only needs to shift SR into OR.
    always_comb begin
        or_d   = or_q;
        or_v_d = or_v;
        sr_d   = sr_q;
        sr_v_d = sr_v;
        if (pop) begin
            if (sr_v) begin
                or_d   = sr_q;
                sr_v_d = 1'b0;
            end else if (accept) begin
                or_d = result;
            end else begin
                or_v_d = 1'b0;
            end
        end else if (accept) begin
            if (!or_v) begin
                or_d   = result;
                or_v_d = 1'b1;
            end else begin
                sr_d   = result;
                sr_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_q <= '0;
            or_v <= 1'b0;
            sr_q <= '0;
            sr_v <= 1'b0;
            acc  <= '0;
        end else begin
            or_q <= or_d;
            or_v <= or_v_d;
            sr_q <= sr_d;
            sr_v <= sr_v_d;
            if (accept) begin
                acc <= result;
            end
        end
    end

`ifdef FUNC_GEN_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (accept) begin
            op_count <= op_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_func_gen_pipe.sv
module tb_func_gen_pipe;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    func_gen_pipe_if #(.WIDTH(8)) bus ();

`ifdef FUNC_GEN_STATS_EN
    logic [3:0] op_count;
`endif

    func_gen_pipe #(
        .WIDTH(8)
`ifdef FUNC_GEN_STATS_EN
        ,
        .COUNT_W(4)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FUNC_GEN_STATS_EN
        ,
        .op_count (op_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge, away from the active edge.
    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] s, input logic c, input logic ordy);
        @(negedge clk);
        bus.in_valid  = v;
        bus.A         = a;
        bus.B         = b;
        bus.sel       = s;
        bus.chain     = c;
        bus.out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp2 [8];

    initial begin
        checks = 0;
        errors = 0;
        exp2 = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h0F, 8'hF0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.sel       = '0;
        bus.chain     = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("rst_F", {8'd0, bus.F}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", {15'd0, bus.in_ready}, 16'd1);

        // All eight functions, one per cycle, full drain.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'hF0, 8'hCC, 3'(i), 1'b0, 1'b1);
            tick();
            check($sformatf("fn%0d_valid", i), {15'd0, bus.out_valid}, 16'd1);
            check($sformatf("fn%0d_F", i), {8'd0, bus.F}, {8'd0, exp2[i]});
        end
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        tick();
        check("drain_valid", {15'd0, bus.out_valid}, 16'd0);

        // Back-pressure: two ops fill OR and SR, third is held.
        drive(1'b1, 8'hAA, 8'h0F, 3'd0, 1'b0, 1'b0);
        tick();
        check("bp1_F", {8'd0, bus.F}, 16'h000A);
        check("bp1_in_ready", {15'd0, bus.in_ready}, 16'd1);
        drive(1'b1, 8'hAA, 8'h0F, 3'd1, 1'b0, 1'b0);
        tick();
        check("bp2_in_ready", {15'd0, bus.in_ready}, 16'd0);
        check("bp2_F_held", {8'd0, bus.F}, 16'h000A);
        drive(1'b1, 8'hAA, 8'h0F, 3'd2, 1'b0, 1'b0);
        tick();
        check("bp3_in_ready", {15'd0, bus.in_ready}, 16'd0);
        check("bp3_F_held", {8'd0, bus.F}, 16'h000A);
        check("bp3_valid", {15'd0, bus.out_valid}, 16'd1);
        drive(1'b1, 8'hAA, 8'h0F, 3'd2, 1'b0, 1'b1);
        tick();
        check("bp4_F_skid", {8'd0, bus.F}, 16'h00AF);
        check("bp4_in_ready", {15'd0, bus.in_ready}, 16'd1);
        tick();
        check("bp5_F_third", {8'd0, bus.F}, 16'h00A5);
        check("bp5_valid", {15'd0, bus.out_valid}, 16'd1);
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        tick();
        check("bp6_valid", {15'd0, bus.out_valid}, 16'd0);

        // Chain accumulation.
        drive(1'b1, 8'h0F, 8'hFF, 3'd2, 1'b0, 1'b1);
        tick();
        check("chain1_F", {8'd0, bus.F}, 16'h00F0);
        drive(1'b1, 8'h55, 8'h33, 3'd0, 1'b1, 1'b1);
        tick();
        check("chain2_F", {8'd0, bus.F}, 16'h0030);
        drive(1'b1, 8'h55, 8'h33, 3'd6, 1'b1, 1'b1);
        tick();
        check("chain3_F", {8'd0, bus.F}, 16'h00CF);

        // Full throughput: XOR with 55 on ten consecutive cycles.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(i), 8'h55, 3'd2, 1'b0, 1'b1);
            check($sformatf("tp%0d_in_ready", i), {15'd0, bus.in_ready}, 16'd1);
            tick();
            check($sformatf("tp%0d_F", i), {8'd0, bus.F}, {8'd0, 8'(i) ^ 8'h55});
            check($sformatf("tp%0d_valid", i), {15'd0, bus.out_valid}, 16'd1);
        end

        // Mid-run reset with data parked in OR and SR.
        drive(1'b1, 8'hFF, 8'h00, 3'd1, 1'b0, 1'b0);
        tick();
        tick();
        check("pre_rst_in_ready", {15'd0, bus.in_ready}, 16'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {15'd0, bus.out_valid}, 16'd0);
        check("midrst_F", {8'd0, bus.F}, 16'd0);
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        rst_n = 1'b1;
        tick();
        check("postrst_in_ready", {15'd0, bus.in_ready}, 16'd1);
        check("postrst_valid", {15'd0, bus.out_valid}, 16'd0);
`ifdef FUNC_GEN_STATS_EN
        check("cnt_reset", {12'd0, op_count}, 16'd0);
`endif
        // acc cleared by reset: chain pass-through of acc yields 00.
        drive(1'b1, 8'hA5, 8'h00, 3'd7, 1'b1, 1'b1);
        tick();
        check("acc_reset_F", {8'd0, bus.F}, 16'h0000);
        check("acc_reset_valid", {15'd0, bus.out_valid}, 16'd1);

`ifdef FUNC_GEN_STATS_EN
        // 1 accept above plus 16 more: 17 total wraps a 4-bit counter to 1.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'h11, 8'h22, 3'd1, 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        tick();
        check("cnt_wrap", {12'd0, op_count}, 16'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("cnt_rst", {12'd0, op_count}, 16'd0);
        rst_n = 1'b1;
`endif

        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
